// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/execute sequencer for the accumulator datapath
module multicycle_ctrl #(
  parameter int DATA_W = 8,
  parameter int OFF_W  = 4,
  parameter int CNT_W  = 16,
  localparam int INSTR_W = 4 + OFF_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  acc,
  input  logic               mem_ready,
  input  logic               run,
  output logic               IRload,
  output logic               PCload,
  output logic               MRload,
  output logic               Aload,
  output logic               RFwr,
  output logic               memWr,
  output logic               MemInst,
  output logic               outen,
  output logic [1:0]         Jmpmuxsel,
  output logic [1:0]         Asel,
  output logic [2:0]         ALUsel,
  output logic [1:0]         Shiftsel,
  output logic               mem_req,
  output logic               halted,
  output logic               retired,
  output logic [CNT_W-1:0]   retired_cnt
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, LDM_A, LDM_D, STM_A, STM_D, HALT
  } state_t;

  state_t state, state_next;

  logic [3:0]       op;
  logic [OFF_W-1:0] f;
  logic             sgn, zero, f_zero, is_jump, cond, exec_mem, exec_done;

  assign op      = instr[INSTR_W-1 -: 4];
  assign f       = instr[OFF_W-1:0];
  assign sgn     = f[OFF_W-1];
  assign zero    = (acc == '0);
  assign f_zero  = (f == '0);
  assign is_jump = (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1000) || (op == 4'b1001);

  always_comb begin
    cond = 1'b0;
    case (op)
      4'b0110: cond = 1'b1;
      4'b0111: cond = zero;
      4'b1000: cond = !zero;
      4'b1001: cond = !acc[DATA_W-1] && !zero;
      default: cond = 1'b0;
    endcase
  end

  // LDI and a taken absolute jump read memory in EXEC; the jump decision is re-evaluated each wait cycle
  assign exec_mem  = (op == 4'b0101) || (is_jump && f_zero && cond);
  assign exec_done = !exec_mem || mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      retired_cnt <= '0;
    end else begin
      state <= state_next;
      if (retired) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          4'b0011: state_next = LDM_A;
          4'b0100: state_next = STM_A;
          4'b1111: state_next = (f == OFF_W'(2)) ? HALT : EXEC;
          default: state_next = EXEC;
        endcase
      end
      EXEC:   if (exec_done) state_next = FETCH;
      LDM_A:  if (mem_ready) state_next = LDM_D;
      LDM_D:  if (mem_ready) state_next = FETCH;
      STM_A:  if (mem_ready) state_next = STM_D;
      STM_D:  if (mem_ready) state_next = FETCH;
      HALT:   if (run) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    IRload    = 1'b0;
    PCload    = 1'b0;
    MRload    = 1'b0;
    Aload     = 1'b0;
    RFwr      = 1'b0;
    memWr     = 1'b0;
    MemInst   = 1'b0;
    outen     = 1'b0;
    Jmpmuxsel = 2'b00;
    Asel      = 2'b00;
    ALUsel    = 3'b000;
    Shiftsel  = 2'b00;
    mem_req   = 1'b0;
    halted    = 1'b0;
    retired   = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          IRload  = mem_ready;
          PCload  = mem_ready;
        end
        DECODE: retired = (op == 4'b1111) && (f == OFF_W'(2));
        EXEC: begin
          retired = exec_done;
          mem_req = exec_mem;
          if (is_jump) begin
            if (f_zero) begin
              Jmpmuxsel = cond ? 2'b01 : 2'b00;
              PCload    = exec_done;
            end else if (cond) begin
              Jmpmuxsel = sgn ? 2'b10 : 2'b11;
              PCload    = 1'b1;
            end
          end else begin
            case (op)
              4'b0001: begin Asel = 2'b01; Aload = 1'b1; end
              4'b0010: RFwr = 1'b1;
              4'b0101: begin Asel = 2'b11; Aload = mem_ready; PCload = mem_ready; end
              4'b1010: begin ALUsel = 3'b001; Aload = 1'b1; end
              4'b1011: begin ALUsel = 3'b010; Aload = 1'b1; end
              4'b1100: begin ALUsel = 3'b100; Aload = 1'b1; end
              4'b1101: begin ALUsel = 3'b101; Aload = 1'b1; end
              4'b1110: begin
                case (f)
                  OFF_W'(0): begin ALUsel = 3'b011; Aload = 1'b1; end
                  OFF_W'(1): begin ALUsel = 3'b110; Aload = 1'b1; end
                  OFF_W'(2): begin ALUsel = 3'b111; Aload = 1'b1; end
                  OFF_W'(3): begin Shiftsel = 2'b01; Aload = 1'b1; end
                  OFF_W'(4): begin Shiftsel = 2'b10; Aload = 1'b1; end
                  OFF_W'(5): begin Shiftsel = 2'b11; Aload = 1'b1; end
                  default: ;
                endcase
              end
              4'b1111: begin
                if (f == OFF_W'(0)) begin Asel = 2'b10; Aload = 1'b1; end
                else if (f == OFF_W'(1)) outen = 1'b1;
              end
              default: ;
            endcase
          end
        end
        LDM_A, STM_A: begin
          mem_req = 1'b1;
          PCload  = mem_ready;
          MRload  = mem_ready;
        end
        LDM_D: begin
          mem_req = 1'b1;
          MemInst = 1'b1;
          Asel    = 2'b11;
          Aload   = mem_ready;
          retired = mem_ready;
        end
        STM_D: begin
          mem_req = 1'b1;
          MemInst = 1'b1;
          memWr   = mem_ready;
          retired = mem_ready;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam int DATA_W = 8;
  localparam int OFF_W  = 4;
  localparam int CNT_W  = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         instr = 8'h00;
  logic [DATA_W-1:0]  acc = '0;
  logic               mem_ready = 1'b0;
  logic               run = 1'b0;
  logic IRload, PCload, MRload, Aload, RFwr, memWr, MemInst, outen;
  logic [1:0] Jmpmuxsel, Asel, Shiftsel;
  logic [2:0] ALUsel;
  logic mem_req, halted, retired;
  logic [CNT_W-1:0] retired_cnt;

  multicycle_ctrl #(.DATA_W(DATA_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .acc(acc), .mem_ready(mem_ready), .run(run),
    .IRload(IRload), .PCload(PCload), .MRload(MRload), .Aload(Aload), .RFwr(RFwr),
    .memWr(memWr), .MemInst(MemInst), .outen(outen), .Jmpmuxsel(Jmpmuxsel), .Asel(Asel),
    .ALUsel(ALUsel), .Shiftsel(Shiftsel), .mem_req(mem_req), .halted(halted),
    .retired(retired), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {IRload, PCload, MRload, Aload, RFwr, memWr, MemInst, outen,
                Jmpmuxsel, Asel, ALUsel, Shiftsel, mem_req, halted, retired};

  localparam logic [19:0] IRL = 20'h80000, PCL = 20'h40000, MRL = 20'h20000, AL = 20'h10000;
  localparam logic [19:0] RFW = 20'h08000, MWR = 20'h04000, MI = 20'h02000, OE = 20'h01000;
  localparam logic [19:0] MRQ = 20'h00004, HLT = 20'h00002, RET = 20'h00001;
  localparam logic [19:0] FET = IRL | PCL | MRQ;

  function automatic logic [19:0] jm(input logic [1:0] x);  return 20'(x) << 10; endfunction
  function automatic logic [19:0] as(input logic [1:0] x);  return 20'(x) << 8;  endfunction
  function automatic logic [19:0] alu(input logic [2:0] x); return 20'(x) << 5;  endfunction
  function automatic logic [19:0] sh(input logic [1:0] x);  return 20'(x) << 3;  endfunction

  typedef struct {
    logic        rst;
    logic [7:0]  ins;
    logic [7:0]  a;
    logic        rdy;
    logic        rn;
    logic [19:0] exp;
  } rec_t;

  rec_t sb[$];
  rec_t r;
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic push(input logic rst, input logic [7:0] ins, input logic [7:0] a,
                      input logic rdy, input logic rn, input logic [19:0] exp);
    rec_t t;
    t.rst = rst; t.ins = ins; t.a = a; t.rdy = rdy; t.rn = rn; t.exp = exp;
    sb.push_back(t);
  endtask

  // zero-wait FETCH, DECODE, EXEC
  task automatic push3(input logic [7:0] ins, input logic [7:0] a, input logic [19:0] exec_exp);
    push(0, ins, a, 1, 0, FET);
    push(0, ins, a, 1, 0, 20'h0);
    push(0, ins, a, 1, 0, exec_exp);
  endtask

  task automatic test_reset;
    push(1, 8'h00, 8'h00, 0, 0, 20'h0);
    push3(8'h00, 8'h00, RET);
    push(0, 8'h00, 8'h00, 0, 0, MRQ);
    push(1, 8'h00, 8'h00, 0, 0, 20'h0);
    push(0, 8'h00, 8'h00, 0, 0, MRQ);
    push(0, 8'h00, 8'h00, 0, 0, MRQ);
    push(0, 8'h00, 8'h00, 1, 0, FET);
    push(0, 8'h00, 8'h00, 1, 0, 20'h0);
    push(0, 8'h00, 8'h00, 1, 0, RET);
    for (int i = 0; sb.size() > 0; i++) begin
      r = sb.pop_front();
      reset = r.rst; instr = r.ins; acc = r.a; mem_ready = r.rdy; run = r.rn;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL reset out rec %0d: got %h want %h", i, obs, r.exp); end
      checks++;
      if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL reset cnt rec %0d: got %0d want %0d", i, retired_cnt, exp_cnt); end
      if (r.rst) exp_cnt = '0; else if (r.exp[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu;
    push3(8'hC3, 8'h00, AL | alu(3'b100) | RET);
    push3(8'hA0, 8'h00, AL | alu(3'b001) | RET);
    push3(8'hD1, 8'h00, AL | alu(3'b101) | RET);
    push3(8'hE0, 8'h00, AL | alu(3'b011) | RET);
    push3(8'hE2, 8'h00, AL | alu(3'b111) | RET);
    push3(8'hE4, 8'h00, AL | sh(2'b10) | RET);
    push3(8'hE5, 8'h00, AL | sh(2'b11) | RET);
    push3(8'hE7, 8'h00, RET);
    push3(8'h10, 8'h00, AL | as(2'b01) | RET);
    push3(8'h20, 8'h00, RFW | RET);
    push3(8'hF0, 8'h00, AL | as(2'b10) | RET);
    push3(8'hF1, 8'h00, OE | RET);
    push3(8'hF5, 8'h00, RET);
    for (int i = 0; sb.size() > 0; i++) begin
      r = sb.pop_front();
      reset = r.rst; instr = r.ins; acc = r.a; mem_ready = r.rdy; run = r.rn;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL alu out rec %0d: got %h want %h", i, obs, r.exp); end
      checks++;
      if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL alu cnt rec %0d: got %0d want %0d", i, retired_cnt, exp_cnt); end
      if (r.rst) exp_cnt = '0; else if (r.exp[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem;
    // LDM with two wait cycles in LDM_D
    push(0, 8'h30, 8'h00, 1, 0, FET);
    push(0, 8'h30, 8'h00, 1, 0, 20'h0);
    push(0, 8'h30, 8'h00, 1, 0, PCL | MRL | MRQ);
    push(0, 8'h30, 8'h00, 0, 0, MI | as(2'b11) | MRQ);
    push(0, 8'h30, 8'h00, 0, 0, MI | as(2'b11) | MRQ);
    push(0, 8'h30, 8'h00, 1, 0, MI | as(2'b11) | AL | MRQ | RET);
    // STM with a wait in FETCH and STM_A
    push(0, 8'h40, 8'h00, 0, 0, MRQ);
    push(0, 8'h40, 8'h00, 1, 0, FET);
    push(0, 8'h40, 8'h00, 1, 0, 20'h0);
    push(0, 8'h40, 8'h00, 0, 0, MRQ);
    push(0, 8'h40, 8'h00, 1, 0, PCL | MRL | MRQ);
    push(0, 8'h40, 8'h00, 1, 0, MI | MWR | MRQ | RET);
    // LDI with one wait
    push(0, 8'h50, 8'h00, 1, 0, FET);
    push(0, 8'h50, 8'h00, 1, 0, 20'h0);
    push(0, 8'h50, 8'h00, 0, 0, as(2'b11) | MRQ);
    push(0, 8'h50, 8'h00, 1, 0, PCL | as(2'b11) | AL | MRQ | RET);
    for (int i = 0; sb.size() > 0; i++) begin
      r = sb.pop_front();
      reset = r.rst; instr = r.ins; acc = r.a; mem_ready = r.rdy; run = r.rn;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL mem out rec %0d: got %h want %h", i, obs, r.exp); end
      checks++;
      if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL mem cnt rec %0d: got %0d want %0d", i, retired_cnt, exp_cnt); end
      if (r.rst) exp_cnt = '0; else if (r.exp[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps;
    push3(8'h7D, 8'h00, PCL | jm(2'b10) | RET);
    push3(8'h7D, 8'h05, RET);
    push3(8'h70, 8'h01, PCL | jm(2'b00) | RET);
    push3(8'h90, 8'h80, PCL | jm(2'b00) | RET);
    push3(8'h90, 8'h01, PCL | jm(2'b01) | MRQ | RET);
    push3(8'h93, 8'h7F, PCL | jm(2'b11) | RET);
    push3(8'h93, 8'h00, RET);
    push3(8'h82, 8'h00, RET);
    push3(8'h82, 8'h40, PCL | jm(2'b11) | RET);
    // absolute JMP waiting on memory
    push(0, 8'h60, 8'h00, 1, 0, FET);
    push(0, 8'h60, 8'h00, 1, 0, 20'h0);
    push(0, 8'h60, 8'h00, 0, 0, jm(2'b01) | MRQ);
    push(0, 8'h60, 8'h00, 1, 0, PCL | jm(2'b01) | MRQ | RET);
    // JNZ absolute whose condition drops during the wait
    push(0, 8'h80, 8'h03, 1, 0, FET);
    push(0, 8'h80, 8'h03, 1, 0, 20'h0);
    push(0, 8'h80, 8'h03, 0, 0, jm(2'b01) | MRQ);
    push(0, 8'h80, 8'h00, 0, 0, PCL | jm(2'b00) | RET);
    for (int i = 0; sb.size() > 0; i++) begin
      r = sb.pop_front();
      reset = r.rst; instr = r.ins; acc = r.a; mem_ready = r.rdy; run = r.rn;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL jumps out rec %0d: got %h want %h", i, obs, r.exp); end
      checks++;
      if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL jumps cnt rec %0d: got %0d want %0d", i, retired_cnt, exp_cnt); end
      if (r.rst) exp_cnt = '0; else if (r.exp[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt;
    push(0, 8'hF2, 8'h00, 1, 0, FET);
    push(0, 8'hF2, 8'h00, 1, 0, RET);
    for (int k = 0; k < 10; k++) push(0, 8'hF2, 8'h00, 1, 0, HLT);
    push(0, 8'hF2, 8'h00, 1, 1, HLT);
    push(0, 8'hF2, 8'h00, 0, 0, MRQ);
    push(0, 8'hF2, 8'h00, 1, 0, FET);
    push(0, 8'hF2, 8'h00, 1, 0, RET);
    push(0, 8'hF2, 8'h00, 1, 0, HLT);
    push(1, 8'hF2, 8'h00, 1, 1, 20'h0);
    push(0, 8'hF2, 8'h00, 0, 0, MRQ);
    for (int i = 0; sb.size() > 0; i++) begin
      r = sb.pop_front();
      reset = r.rst; instr = r.ins; acc = r.a; mem_ready = r.rdy; run = r.rn;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL halt out rec %0d: got %h want %h", i, obs, r.exp); end
      checks++;
      if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL halt cnt rec %0d: got %0d want %0d", i, retired_cnt, exp_cnt); end
      if (r.rst) exp_cnt = '0; else if (r.exp[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back_wrap;
    int n;
    n = (1 << CNT_W) - int'(exp_cnt);
    for (int k = 0; k < n; k++) push3(8'h00, 8'h00, RET);
    for (int k = 0; k < 2; k++) push3(8'h00, 8'h00, RET);
    for (int i = 0; sb.size() > 0; i++) begin
      r = sb.pop_front();
      reset = r.rst; instr = r.ins; acc = r.a; mem_ready = r.rdy; run = r.rn;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL wrap out rec %0d: got %h want %h", i, obs, r.exp); end
      checks++;
      if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL wrap cnt rec %0d: got %0d want %0d", i, retired_cnt, exp_cnt); end
      if (r.rst) exp_cnt = '0; else if (r.exp[0]) exp_cnt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (retired_cnt !== CNT_W'(2)) begin errors++; $display("FAIL wrap final cnt: got %0d want 2", retired_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_alu;
    test_mem;
    test_jumps;
    test_halt;
    test_back_to_back_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle control unit for the accumulator processor datapath. It sequences fetch/decode/execute for the 16-opcode ISA and drives the datapath strobes. The instruction word width and accumulator width are configurable. It adds a memory wait-state handshake, a resumable HALT, a correct signed JP test and a retired-instruction counter. It sits between the instruction register/accumulator and the datapath muxes/registers.

## Interface
- DATA_W, 8: accumulator width; width of `acc`.
- OFF_W, 4: relative-offset field width; INSTR_W = 4 + OFF_W; opcode = instr[INSTR_W-1 -: 4]; field F = instr[OFF_W-1:0], sign = F[OFF_W-1].
- CNT_W, 16: retired-instruction counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr  in  INSTR_W  IR contents; stable from DECODE onward.
- acc  in  DATA_W  accumulator value, used for branch conditions.
- mem_ready  in  1  memory completes the current access this cycle.
- run  in  1  resume from HALT.
- IRload, PCload, MRload, Aload, RFwr, memWr, MemInst, outen  out  1  datapath strobes.
- Jmpmuxsel  out  2  PC source: 00 PC+1, 01 memory (absolute), 10 PC−|F|, 11 PC+F.
- Asel  out  2  A source: 00 ALU, 01 RF, 10 input port, 11 memory.
- ALUsel  out  3  000 pass, 001 AND, 010 OR, 011 NOT, 100 ADD, 101 SUB, 110 INC, 111 DEC.
- Shiftsel  out  2  00 none, 01 SHFL, 10 SHFR, 11 ROTR.
- mem_req  out  1  memory access in progress.
- halted  out  1  state is HALT.
- retired  out  1  one-cycle pulse when an instruction completes.
- retired_cnt  out  CNT_W  completed-instruction count; wraps modulo 2^CNT_W.

## Operation
- States: FETCH, DECODE, EXEC, LDM_A, LDM_D, STM_A, STM_D, HALT. Strobes decode combinationally from the registered state, latched opcode, `acc` and `mem_ready`. Every strobe not listed for a state is 0.
- Memory states: FETCH, LDM_A, LDM_D, STM_A, STM_D, EXEC-LDI and EXEC-taken-absolute-jump.
  - `mem_req`=1 and MemInst are held for the whole access.
  - The state holds while mem_ready=0.
  - IRload/PCload/MRload/Aload/memWr assert only in the cycle mem_ready=1, and the state advances in that cycle.
- FETCH: IRload, PCload, Jmpmuxsel=00, MemInst=0 → DECODE.
- DECODE: all strobes 0. Next state by opcode:
  - 0011 → LDM_A.
  - 0100 → STM_A.
  - 1111 with F=2 → HALT.
  - all other opcodes → EXEC.
- EXEC actions by opcode:
  - 0000: no strobes.
  - 0001 LDA: Asel=01, Aload.
  - 0010 STA: RFwr.
  - 0101 LDI: PCload, Asel=11, Aload (memory access).
  - 1010/1011/1100/1101: Aload, Asel=00, ALUsel 001/010/100/101.
  - 1110 unary: F=0..5 → NOT/INC/DEC (ALUsel 011/110/111) or SHFL/SHFR/ROTR (ALUsel 000, Shiftsel 01/10/11), each with Aload. F>5 → no strobes.
  - 1111: F=0 IN (Asel=10, Aload); F=1 OUT (outen); other F → no strobes.
- Jumps (opcodes 0110 JMP, 0111 JZ, 1000 JNZ, 1001 JP):
  - Conditions: Z = (acc==0). JZ cond=Z, JNZ cond=!Z, JP cond = !acc[DATA_W-1] && !Z, JMP always true.
  - F=0 (absolute): if taken, PCload with Jmpmuxsel=01 (memory access); if not taken, PCload with Jmpmuxsel=00 to skip the address word.
  - F≠0 (relative): if taken, PCload with Jmpmuxsel 11 (sign=0) or 10 (sign=1); if not taken, no strobes.
- LDM: LDM_A does PCload and MRload → LDM_D. LDM_D does MemInst, Asel=11, Aload → FETCH.
- STM: STM_A does PCload and MRload → STM_D. STM_D does MemInst and memWr → FETCH.
- EXEC, LDM_D and STM_D go to FETCH on completion. The completing cycle pulses `retired` and increments `retired_cnt`.
- HALT: all strobes 0, halted=1. HALT itself counts as retired on entry (the DECODE→HALT cycle). run=1 → FETCH.

## Timing
- Reset: in the cycle reset=1, all strobes, mem_req, retired and halted read 0. Next state is FETCH and retired_cnt is cleared. Reset overrides a pending memory wait or HALT.
- Zero-wait latencies:
  - ALU, jump, IN/OUT: 3 cycles (FETCH, DECODE, EXEC).
  - LDM/STM: 4 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- `retired` is asserted in the same cycle as the final strobe. The counter value is visible the next cycle.
- `acc` is sampled combinationally in EXEC. The branch decision may change while an absolute-jump access waits; it is committed in the mem_ready cycle.

## Test plan
- Reset mid-wait: enter FETCH with mem_ready=0, assert reset → next cycle state FETCH, all outputs 0, retired_cnt=0.
- ADD (instr=0xC3, mem_ready=1): IRload+PCload in cycle 0; DECODE in cycle 1; Aload=1 with ALUsel=100 in cycle 2; retired pulse; retired_cnt=1.
- LDM with mem_ready low for 2 cycles in LDM_D → MemInst held for 3 cycles, Aload only in the third; total 6 cycles.
- JZR instr=0x7D (F=−3), acc=0 → PCload with Jmpmuxsel=10. Same with acc=5 → no strobes. JZR instr=0x70 with acc=1 → PCload with Jmpmuxsel=00.
- JP instr=0x90: acc=0x80 → not taken (Jmpmuxsel=00). acc=0x01 → taken (Jmpmuxsel=01).
- HALT (0xF2): halted=1 held while run=0 for 10 cycles with no strobes. run=1 → FETCH next cycle. retired_cnt has wrapped to 0 after 2^CNT_W NOPs.
